// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer driving decoder strobes, execute, memory handshake, writeback and PC increment.
// Optional build macro ILLEGAL_HALT_EN: an instruction with no class strobe parks the FSM in HALT until reset.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             ALUstr,
    input  logic             MOVstr,
    input  logic             LDSRstr,
    input  logic [3:0]       opCode,
    input  logic             mem_ready,
    output logic             IF,
    output logic             IR,
    output logic             IRiEn,
    output logic             IRjEn,
    output logic             BRjEn,
    output logic             alu_go,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_inc,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_SELI, S_SELJ,
        S_EXEC, S_MEM, S_WB, S_NEXT, S_HALT
    } state_t;

    typedef enum logic [1:0] {C_ALU, C_MOV, C_LDSR, C_ILL} cls_t;

    localparam logic [3:0] OP_ADDI  = 4'd7;
    localparam logic [3:0] OP_SUBI  = 4'd8;
    localparam logic [3:0] OP_MOVI  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd12;

    state_t     state, nxt;
    cls_t       cls_q, cls_d;
    logic [3:0] op_q;
    logic [7:0] tcnt;
    logic       timeout, imm;

    logic if_d, ir_d, iri_d, irj_d, brj_d, alu_d, mreq_d, mwe_d, rwe_d, pc_d, berr_d, halt_d;

    always_comb begin
        cls_d = C_ILL;
        if (ALUstr)       cls_d = C_ALU;
        else if (MOVstr)  cls_d = C_MOV;
        else if (LDSRstr) cls_d = C_LDSR;
    end

    // ready in the expiry cycle takes priority over the abort
    assign timeout = (state == S_MEM) && !mem_ready && (tcnt == 8'(MEM_TIMEOUT - 1));
    assign imm     = (op_q == OP_ADDI) || (op_q == OP_SUBI) || (op_q == OP_MOVI);

    // state register; outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cls_q   <= C_ILL;
            op_q    <= '0;
            tcnt    <= '0;
            retired <= '0;
            IF      <= 1'b0;
            IR      <= 1'b0;
            IRiEn   <= 1'b0;
            IRjEn   <= 1'b0;
            BRjEn   <= 1'b0;
            alu_go  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            reg_we  <= 1'b0;
            pc_inc  <= 1'b0;
            bus_err <= 1'b0;
            halted  <= 1'b1;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                cls_q <= cls_d;
                op_q  <= opCode;
            end
            tcnt <= (state == S_MEM) ? tcnt + 8'd1 : 8'd0;
            if (nxt == S_NEXT && !timeout)
                retired <= retired + 1'b1;
            IF      <= if_d;
            IR      <= ir_d;
            IRiEn   <= iri_d;
            IRjEn   <= irj_d;
            BRjEn   <= brj_d;
            alu_go  <= alu_d;
            mem_req <= mreq_d;
            mem_we  <= mwe_d;
            reg_we  <= rwe_d;
            pc_inc  <= pc_d;
            bus_err <= berr_d;
            halted  <= halt_d;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH:  nxt = S_LATCH;
            S_LATCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (cls_d != C_ILL) nxt = S_SELI;
`ifdef ILLEGAL_HALT_EN
                else                nxt = S_HALT;
`else
                else                nxt = S_NEXT;
`endif
            end
            S_SELI:   nxt = S_SELJ;
            S_SELJ:   nxt = S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_ALU:   nxt = S_WB;
                    C_MOV:   nxt = S_NEXT;
                    default: nxt = S_MEM;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    nxt = (op_q == OP_STORE) ? S_NEXT : S_WB;
                else if (timeout) nxt = S_NEXT;
            end
            S_WB:     nxt = S_NEXT;
            S_NEXT:   nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        if_d   = (nxt == S_FETCH);
        ir_d   = (nxt == S_LATCH);
        iri_d  = (nxt == S_SELI);
        irj_d  = (nxt == S_SELJ) && !imm;
        brj_d  = (nxt == S_SELJ) && imm;
        alu_d  = (nxt == S_EXEC) && (cls_q == C_ALU);
        mreq_d = (nxt == S_MEM);
        mwe_d  = (nxt == S_MEM) && (op_q == OP_STORE);
        rwe_d  = (nxt == S_WB) || ((nxt == S_EXEC) && (cls_q == C_MOV));
        pc_d   = (nxt == S_NEXT);
        berr_d = timeout;
        halt_d = (nxt == S_IDLE) || (nxt == S_HALT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: per-instruction pulse counts, latency and retire count.
module tb_control_sequencer;
    localparam int TMO = 15;

    logic        clk = 1'b0, reset = 1'b0, run = 1'b0;
    logic        ALUstr = 1'b0, MOVstr = 1'b0, LDSRstr = 1'b0, mem_ready = 1'b0;
    logic [3:0]  opCode = '0;
    logic        IF, IR, IRiEn, IRjEn, BRjEn, alu_go, mem_req, mem_we, reg_we, pc_inc, bus_err, halted;
    logic [15:0] retired;

    control_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .ALUstr(ALUstr), .MOVstr(MOVstr), .LDSRstr(LDSRstr),
        .opCode(opCode), .mem_ready(mem_ready), .IF(IF), .IR(IR), .IRiEn(IRiEn), .IRjEn(IRjEn),
        .BRjEn(BRjEn), .alu_go(alu_go), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .pc_inc(pc_inc), .bus_err(bus_err), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int w; } instr_t;
    typedef struct { int lat, iri, irj, brj, alu, rwe, mreq, mwe, berr, ret; } exp_t;

    instr_t prog[$];
    exp_t   exp_q[$];
    int     n_chk = 0, n_fail = 0;
    int     model_ret = 0;
    int     pc_total = 0;

    task automatic chk(string nm, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic bound_fail(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Reference: what one instruction must produce, from its opcode and memory wait alone
    task automatic issue(int op, int w);
        exp_t e;
        bit alu, mov, ldsr, ill, imm, st, to;
        int mc;
        alu  = op <= 8;
        mov  = op == 9 || op == 10;
        ldsr = op == 11 || op == 12;
        ill  = op >= 13;
        imm  = op == 7 || op == 8 || op == 9;
        st   = op == 12;
        to   = ldsr && w >= TMO;
        mc   = !ldsr ? 0 : (to ? TMO : w + 1);
        prog.push_back('{op, w});
`ifdef ILLEGAL_HALT_EN
        if (ill) return;
`endif
        if (!to) model_ret++;
        e.lat  = ill ? 4 : alu ? 8 : mov ? 7 : (to ? 7 + mc : (st ? 7 + mc : 8 + mc));
        e.iri  = ill ? 0 : 1;
        e.irj  = (!ill && !imm) ? 1 : 0;
        e.brj  = (!ill && imm) ? 1 : 0;
        e.alu  = alu ? 1 : 0;
        e.rwe  = (alu || mov || (ldsr && !st && !to)) ? 1 : 0;
        e.mreq = mc;
        e.mwe  = st ? mc : 0;
        e.berr = to ? 1 : 0;
        e.ret  = model_ret % 65536;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(string nm, int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (prog.size() == 0 && exp_q.size() == 0 && halted) return;
        end
        bound_fail(nm);
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_IF"}, int'(IF), 0);       chk({tag, "_IR"}, int'(IR), 0);
        chk({tag, "_IRiEn"}, int'(IRiEn), 0); chk({tag, "_IRjEn"}, int'(IRjEn), 0);
        chk({tag, "_BRjEn"}, int'(BRjEn), 0); chk({tag, "_alu_go"}, int'(alu_go), 0);
        chk({tag, "_mem_req"}, int'(mem_req), 0); chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_reg_we"}, int'(reg_we), 0); chk({tag, "_pc_inc"}, int'(pc_inc), 0);
        chk({tag, "_bus_err"}, int'(bus_err), 0); chk({tag, "_halted"}, int'(halted), 1);
        chk({tag, "_retired"}, int'(retired), 0);
    endtask

    initial begin
        int cur_op, cur_w, mcnt;
        bit active;
        int cyc, c_if, c_ir, c_iri, c_irj, c_brj, c_alu, c_rwe, c_mreq, c_mwe, c_berr;
        cur_op = 0; cur_w = 0; mcnt = 0; active = 0;
        cyc = 0; c_if = 0; c_ir = 0; c_iri = 0; c_irj = 0; c_brj = 0;
        c_alu = 0; c_rwe = 0; c_mreq = 0; c_mwe = 0; c_berr = 0;
        fork
            // decoder + instruction memory + data memory model
            forever begin
                @(negedge clk);
                if (reset) begin
                    ALUstr = 0; MOVstr = 0; LDSRstr = 0; mem_ready = 0; mcnt = 0;
                end else begin
                    if (IF) begin
                        ALUstr = 0; MOVstr = 0; LDSRstr = 0;
                        if (prog.size() > 0) begin
                            instr_t it;
                            it = prog.pop_front();
                            cur_op = it.op; cur_w = it.w; opCode = 4'(it.op);
                        end
                    end
                    if (IR) begin
                        ALUstr  = cur_op <= 8;
                        MOVstr  = cur_op == 9 || cur_op == 10;
                        LDSRstr = cur_op == 11 || cur_op == 12;
                    end
                    if (mem_req) begin
                        mem_ready = (mcnt == cur_w);
                        mcnt++;
                    end else begin
                        mem_ready = 0; mcnt = 0;
                    end
                end
                run = !reset && prog.size() > 0;
            end
            // monitor: accumulate one instruction from IF to pc_inc and score it
            forever begin
                @(negedge clk);
                if (reset) begin
                    active = 0;
                    exp_q.delete();
                end else begin
                    if (pc_inc) pc_total++;
                    if (IF) begin
                        active = 1; cyc = 0; c_if = 0; c_ir = 0; c_iri = 0; c_irj = 0; c_brj = 0;
                        c_alu = 0; c_rwe = 0; c_mreq = 0; c_mwe = 0; c_berr = 0;
                    end
                    if (active) begin
                        cyc++;
                        c_if += int'(IF); c_ir += int'(IR); c_iri += int'(IRiEn);
                        c_irj += int'(IRjEn); c_brj += int'(BRjEn); c_alu += int'(alu_go);
                        c_rwe += int'(reg_we); c_mreq += int'(mem_req);
                        c_mwe += int'(mem_we && mem_req); c_berr += int'(bus_err);
                        if (pc_inc) begin
                            active = 0;
                            if (exp_q.size() == 0) bound_fail("unexpected_retire");
                            else begin
                                exp_t e;
                                e = exp_q.pop_front();
                                chk("latency", cyc, e.lat);     chk("IF_cnt", c_if, 1);
                                chk("IR_cnt", c_ir, 1);          chk("IRiEn_cnt", c_iri, e.iri);
                                chk("IRjEn_cnt", c_irj, e.irj);  chk("BRjEn_cnt", c_brj, e.brj);
                                chk("alu_go_cnt", c_alu, e.alu); chk("reg_we_cnt", c_rwe, e.rwe);
                                chk("mem_req_cyc", c_mreq, e.mreq); chk("mem_we_cyc", c_mwe, e.mwe);
                                chk("bus_err_cnt", c_berr, e.berr); chk("retired", int'(retired), e.ret);
                            end
                        end
                    end else if (pc_inc) bound_fail("stray_pc_inc");
                end
            end
            // stimulus
            begin
                #2 reset = 1;
                repeat (2) @(negedge clk);
                chk_reset_state("rst");
                reset = 0;
                repeat (2) @(negedge clk);
                chk("idle_halted", int'(halted), 1);

                // directed: ADD, ADDI, LOAD wait 3, STORE no ready, illegal, MOVI, MOV, ready at expiry, STORE
                issue(0, 0); issue(7, 0); issue(11, 3); issue(12, 255);
`ifndef ILLEGAL_HALT_EN
                issue(14, 0);
`endif
                issue(9, 0); issue(10, 0); issue(11, 14); issue(12, 0);
                wait_done("directed", 400);
                repeat (4) @(negedge clk);
                chk("stopped_halted", int'(halted), 1);
                chk("stopped_retired", int'(retired), model_ret);

                for (int n = 0; n < 60; n++) begin
                    int op, w;
`ifdef ILLEGAL_HALT_EN
                    op = int'($urandom_range(0, 12));
`else
                    op = int'($urandom_range(0, 15));
`endif
                    w = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 16));
                    issue(op, w);
                end
                wait_done("random", 3000);

                // reset while waiting in MEM
                issue(12, 255);
                begin
                    bit seen;
                    seen = 0;
                    for (int i = 0; i < 50 && !seen; i++) begin
                        @(negedge clk);
                        seen = mem_req;
                    end
                    if (!seen) bound_fail("reach_mem");
                end
                repeat (3) @(negedge clk);
                #2 reset = 1;
                #1 chk_reset_state("midrst");
                model_ret = 0;
                repeat (2) @(negedge clk);
                reset = 0;
                issue(1, 0); issue(11, 0);
                wait_done("after_reset", 200);
`ifdef ILLEGAL_HALT_EN
                begin
                    int pc0;
                    pc0 = pc_total;
                    issue(14, 0);
                    repeat (40) @(negedge clk);
                    chk("halt_halted", int'(halted), 1);
                    chk("halt_no_pc_inc", pc_total - pc0, 0);
                end
`endif
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
